// File: rtl/sort_stream_loader.sv
// Stream loader/unloader around the bit-serial bubble-sort array: fills slots, pads, starts, drains.
// Optional watchdog (abort/err on a stuck sorter) is enabled by defining SORT_TIMEOUT_EN.
module sort_stream_loader #(
  parameter int unsigned N_BITS    = 8,
  parameter int unsigned K_NUMBERS = 49,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [N_BITS-1:0]             s_data,
  input  logic                          s_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [N_BITS-1:0]             m_data,
  output logic                          m_last,
  output logic [K_NUMBERS-1:0]          load_o,
  output logic [K_NUMBERS*N_BITS-1:0]   writedata_o,
  input  logic [K_NUMBERS*N_BITS-1:0]   readdata_i,
  output logic                          start_o,
  input  logic                          done_i,
  output logic                          abort_o,
  output logic                          busy_o,
  output logic                          err_o
);

  localparam int unsigned CW = $clog2(K_NUMBERS + 1);

  typedef enum logic [2:0] {S_FILL, S_PAD, S_START, S_WAIT, S_DRAIN} state_t;

  state_t            r_state, w_next;
  logic [CW-1:0]     r_count, r_idx;
  logic              w_s_hs, w_m_hs, w_close, w_full, w_last_out, w_expire;
  logic [N_BITS-1:0] w_lane;

  assign s_ready     = (r_state == S_FILL);
  assign m_valid     = (r_state == S_DRAIN);
  assign start_o     = (r_state == S_START);
  assign busy_o      = !((r_state == S_FILL) && (r_count == '0));
  assign w_s_hs      = s_valid & s_ready;
  assign w_m_hs      = m_valid & m_ready;
  assign w_full      = (r_count == CW'(K_NUMBERS - 1));
  assign w_close     = w_s_hs & (s_last | w_full);
  assign w_last_out  = (r_idx == r_count - CW'(1));
  assign m_last      = m_valid & w_last_out;
  assign m_data      = readdata_i[r_idx*N_BITS +: N_BITS];
  assign writedata_o = {K_NUMBERS{w_lane}};

`ifdef SORT_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] r_wd;

  always_ff @(posedge clk) begin
    if (rst)                     r_wd <= '0;
    else if (r_state == S_START) r_wd <= '0;
    else if (r_state == S_WAIT)  r_wd <= r_wd + WW'(1);
  end

  // A done_i arriving in the expiry cycle takes priority over the abort.
  assign w_expire = (r_state == S_WAIT) & ~done_i & (r_wd == WW'(TIMEOUT - 1));
`else
  assign w_expire = 1'b0;
`endif

  assign abort_o = w_expire;
  assign err_o   = w_expire;

  always_comb begin
    w_next = r_state;
    load_o = '0;
    w_lane = s_data;
    case (r_state)
      S_FILL: begin
        if (w_s_hs) begin
          for (int unsigned j = 0; j < K_NUMBERS; j++)
            load_o[j] = (r_count == CW'(j));
          if (w_close) w_next = w_full ? S_START : S_PAD;
        end
      end
      S_PAD: begin
        w_lane = '1;
        for (int unsigned j = 0; j < K_NUMBERS; j++)
          load_o[j] = (CW'(j) >= r_count);
        w_next = S_START;
      end
      S_START: w_next = S_WAIT;
      S_WAIT: begin
        if (done_i)        w_next = S_DRAIN;
        else if (w_expire) w_next = S_FILL;
      end
      S_DRAIN: begin
        if (w_m_hs && w_last_out) w_next = S_FILL;
      end
      default: w_next = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FILL;
      r_count <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_FILL: if (w_s_hs) r_count <= r_count + CW'(1);
        S_WAIT: begin
          r_idx <= '0;
          if (w_expire) r_count <= '0;
        end
        S_DRAIN: begin
          if (w_m_hs) begin
            r_idx <= r_idx + CW'(1);
            if (w_last_out) r_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_stream_loader.sv
// Directed bench for sort_stream_loader with a behavioural sorter model driving readdata_i/done_i.
module tb_sort_stream_loader;
  localparam int N = 8;
  localparam int K = 49;

  logic             clk = 1'b0;
  logic             rst, s_valid, s_ready, s_last, m_valid, m_ready, m_last;
  logic [N-1:0]     s_data, m_data;
  logic [K-1:0]     load_o;
  logic [K*N-1:0]   writedata_o, rd;
  logic             start_o, done_i, abort_o, busy_o, err_o;

  int checks = 0;
  int failures = 0;
  logic [N-1:0] slot [K];
  logic [N-1:0] exp_q [$];
  logic [K-1:0] oh, pm;

  always #5 clk = ~clk;

  sort_stream_loader #(.N_BITS(N), .K_NUMBERS(K), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .load_o(load_o), .writedata_o(writedata_o), .readdata_i(rd),
    .start_o(start_o), .done_i(done_i), .abort_o(abort_o), .busy_o(busy_o), .err_o(err_o)
  );

  // Sorter slot storage, written by the loader's strobes.
  always @(posedge clk)
    for (int j = 0; j < K; j++)
      if (load_o[j]) slot[j] <= writedata_o[j*N +: N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sorter_done();
    logic [N-1:0] t [K];
    logic [N-1:0] x;
    t = slot;
    for (int a = 0; a < K-1; a++)
      for (int b = 0; b < K-1-a; b++)
        if (t[b] > t[b+1]) begin x = t[b]; t[b] = t[b+1]; t[b+1] = x; end
    for (int j = 0; j < K; j++) rd[j*N +: N] = t[j];
    @(negedge clk); done_i = 1'b1;
    @(posedge clk); #1 done_i = 1'b0;
  endtask

  task automatic send(input logic [N-1:0] d, input logic l, input int k);
    @(negedge clk);
    s_valid = 1'b1; s_data = d; s_last = l;
    #1;
    oh = '0; oh[k] = 1'b1;
    chk("fill_load", load_o, oh);
    chk("fill_lane", writedata_o[N*(K-1) +: N], d);
    chk("fill_ready", s_ready, 1'b1);
  endtask

  task automatic drain_all(input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk); m_ready = 1'b1; #1;
      chk({tag, "_valid"}, m_valid, 1'b1);
      chk({tag, "_data"}, m_data, exp_q[i]);
      chk({tag, "_last"}, m_last, i == exp_q.size() - 1);
      chk({tag, "_sready"}, s_ready, 1'b0);
    end
    @(negedge clk); m_ready = 1'b0; #1;
    chk({tag, "_end_valid"}, m_valid, 1'b0);
    chk({tag, "_end_sready"}, s_ready, 1'b1);
    chk({tag, "_end_busy"}, busy_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    m_ready = 1'b0; done_i = 1'b0; rd = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_sready", s_ready, 1'b1);
    chk("rst_mvalid", m_valid, 1'b0);
    chk("rst_mlast", m_last, 1'b0);
    chk("rst_load", load_o, '0);
    chk("rst_start", start_o, 1'b0);
    chk("rst_abort", abort_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    rst = 1'b0;

    // 1) 5,3,9,1 with padding
    send(8'd5, 1'b0, 0); send(8'd3, 1'b0, 1); send(8'd9, 1'b0, 2); send(8'd1, 1'b1, 3);
    @(negedge clk); s_valid = 1'b0; s_last = 1'b0; #1;
    pm = '1; for (int j = 0; j < 4; j++) pm[j] = 1'b0;
    chk("t1_pad_load", load_o, pm);
    chk("t1_pad_lane", writedata_o[0 +: N], 8'hFF);
    chk("t1_pad_sready", s_ready, 1'b0);
    chk("t1_pad_start", start_o, 1'b0);
    chk("t1_pad_busy", busy_o, 1'b1);
    @(negedge clk); #1;
    chk("t1_start", start_o, 1'b1);
    @(negedge clk); #1;
    chk("t1_wait_start", start_o, 1'b0);
    chk("t1_slot0", slot[0], 8'd5);
    chk("t1_slot3", slot[3], 8'd1);
    chk("t1_slot4", slot[4], 8'hFF);
    chk("t1_slot48", slot[48], 8'hFF);
    exp_q = '{8'd1, 8'd3, 8'd5, 8'd9};
    sorter_done();
    drain_all("t1");

    // 2) full frame 48..0 without s_last, 50th word stalls
    for (int k = 0; k < K; k++) send(8'(48 - k), 1'b0, k);
    @(negedge clk); s_valid = 1'b1; s_data = 8'h77; s_last = 1'b1; #1;
    chk("t2_start", start_o, 1'b1);
    chk("t2_sready", s_ready, 1'b0);
    chk("t2_noload", load_o, '0);
    @(negedge clk); #1;
    chk("t2_wait_sready", s_ready, 1'b0);
    exp_q = {};
    for (int i = 0; i < K; i++) exp_q.push_back(8'(i));
    sorter_done();
    drain_all("t2");
    oh = '0; oh[0] = 1'b1;
    chk("t2_50th_load", load_o, oh);
    @(negedge clk); s_valid = 1'b0; s_last = 1'b0; #1;
    pm = '1; pm[0] = 1'b0;
    chk("t2_single_pad", load_o, pm);
    @(negedge clk); #1;
    chk("t2_single_start", start_o, 1'b1);
    exp_q = '{8'h77};
    sorter_done();
    drain_all("t2s");

    // 3) values containing 8'hFF
    send(8'd7, 1'b0, 0); send(8'hFF, 1'b0, 1); send(8'd2, 1'b1, 2);
    @(negedge clk); s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk); #1;
    chk("t3_start", start_o, 1'b1);
    exp_q = '{8'd2, 8'd7, 8'hFF};
    sorter_done();
    drain_all("t3");
    @(negedge clk); #1;
    chk("t3_no_extra", m_valid, 1'b0);

    // 4) back-pressure toggling
    send(8'd40, 1'b0, 0); send(8'd10, 1'b0, 1); send(8'd30, 1'b0, 2); send(8'd20, 1'b1, 3);
    @(negedge clk); s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk); #1;
    chk("t4_start", start_o, 1'b1);
    exp_q = '{8'd10, 8'd20, 8'd30, 8'd40};
    sorter_done();
    begin
      int got = 0;
      int cyc = 0;
      logic tog = 1'b0;
      while (got < 4 && cyc < 20) begin
        @(negedge clk); m_ready = tog; #1;
        chk("t4_valid", m_valid, 1'b1);
        chk("t4_data", m_data, exp_q[got]);
        chk("t4_last", m_last, got == 3);
        if (tog) got++;
        tog = ~tog;
        cyc++;
      end
      chk("t4_count", got, 4);
    end
    @(negedge clk); m_ready = 1'b0; #1;
    chk("t4_end_valid", m_valid, 1'b0);

    // 5) reset during WAIT
    send(8'h42, 1'b1, 0);
    @(negedge clk); s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("t5_wait_busy", busy_o, 1'b1);
    chk("t5_wait_sready", s_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("t5_sready", s_ready, 1'b1);
    chk("t5_mvalid", m_valid, 1'b0);
    chk("t5_busy", busy_o, 1'b0);
    @(negedge clk); done_i = 1'b1;
    @(posedge clk); #1 done_i = 1'b0;
    @(negedge clk); #1;
    chk("t5_done_ignored", m_valid, 1'b0);
    chk("t5_still_fill", s_ready, 1'b1);
    chk("t5_no_start", start_o, 1'b0);

    // 6) withheld done_i
    send(8'd3, 1'b0, 0); send(8'd1, 1'b1, 1);
    @(negedge clk); s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk); #1;
    chk("t6_start", start_o, 1'b1);
`ifdef SORT_TIMEOUT_EN
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); #1;
      chk("t6_abort", abort_o, k == 16);
      chk("t6_err", err_o, k == 16);
      chk("t6_mvalid", m_valid, 1'b0);
    end
    chk("t6_fill_sready", s_ready, 1'b1);
    chk("t6_fill_busy", busy_o, 1'b0);
`else
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); #1;
      chk("t6_abort", abort_o, 1'b0);
      chk("t6_err", err_o, 1'b0);
      chk("t6_mvalid", m_valid, 1'b0);
    end
    exp_q = '{8'd1, 8'd3};
    sorter_done();
    drain_all("t6a");
`endif
    send(8'd9, 1'b0, 0); send(8'd4, 1'b1, 1);
    @(negedge clk); s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk); #1;
    chk("t6_next_start", start_o, 1'b1);
    exp_q = '{8'd4, 8'd9};
    sorter_done();
    drain_all("t6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
